// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter
//   Shares the quad-SPI pin group between instruction fetch (requester 0)
//   and the data load/store port (requester 1). Grants are round-robin,
//   the granted requester's chip enable is driven low, a minimum CE-high
//   gap separates transactions, and a long-running owner is asked to
//   yield when the other requester is waiting.
//
// Ports
//   clk_osc              system clock
//   rst_n                synchronous active-low reset
//   req[1:0]             per-requester bus request (level)
//   ce_sel0/1[1:0]       target chip per requester (3 is illegal)
//   done[1:0]            end-of-transaction pulse, honoured from the owner only
//   sclk_r[1:0]          per-requester SPI clock
//   sio_o_r0/1[3:0]      per-requester sio output data
//   sio_oe_r0/1[3:0]     per-requester sio output enables
//   gnt[1:0]             registered grant, one-hot or zero
//   yield[1:0]           registered request to the owner to finish
//   err[1:0]             one-cycle pulse on a request rejected for ce_sel=3
//   ce[2:0]              active-low chip enables
//   sclk, sio_o, sio_oe  pins, muxed from the current owner
module qspi_bus_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD   = 64
) (
  input  logic       clk_osc,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] ce_sel0,
  input  logic [1:0] ce_sel1,
  input  logic [1:0] done,
  input  logic [1:0] sclk_r,
  input  logic [3:0] sio_o_r0,
  input  logic [3:0] sio_o_r1,
  input  logic [3:0] sio_oe_r0,
  input  logic [3:0] sio_oe_r1,
  output logic [1:0] gnt,
  output logic [1:0] yield,
  output logic [1:0] err,
  output logic [2:0] ce,
  output logic       sclk,
  output logic [3:0] sio_o,
  output logic [3:0] sio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] MAX_HOLD_L = 16'(MAX_HOLD);
  // The gap counter is loaded with G-1 so that GAP lasts exactly G cycles.
  localparam logic [3:0]  GAP_LOAD   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  gnt_d, yield_d, err_d;
  logic [2:0]  ce_d;
  logic        ptr_q, ptr_d;
  logic [15:0] hold_q, hold_d, hold_inc;
  logic [3:0]  gap_q, gap_d;
  logic        owner;
  logic        pick;
  logic [1:0]  pick_sel;

  // gnt is one-hot while BUSY, so bit 1 alone identifies the owner.
  assign owner = gnt[1];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    yield_d  = yield;
    err_d    = 2'b00;
    ce_d     = ce;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    pick     = 1'b0;
    pick_sel = 2'd0;
    hold_inc = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // Contention resolved by the pointer; a lone request wins outright.
          pick     = (req == 2'b11) ? ptr_q : req[1];
          pick_sel = pick ? ce_sel1 : ce_sel0;
          ptr_d    = ~pick;
          if (pick_sel == 2'd3) begin
            err_d[pick] = 1'b1;
          end else begin
            gnt_d   = pick ? 2'b10 : 2'b01;
            ce_d    = ~(3'b001 << pick_sel);
            hold_d  = 16'd0;
            yield_d = 2'b00;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (done[owner]) begin
          gnt_d   = 2'b00;
          yield_d = 2'b00;
          ce_d    = 3'b111;
          gap_d   = GAP_LOAD;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          // Hold count is monotonic and saturating, so re-evaluating the
          // yield condition every cycle gives set/clear behaviour directly.
          hold_d         = hold_inc;
          yield_d        = 2'b00;
          yield_d[owner] = (hold_inc >= MAX_HOLD_L) && req[~owner];
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_osc) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= 2'b00;
      yield   <= 2'b00;
      err     <= 2'b00;
      ce      <= 3'b111;
      ptr_q   <= 1'b0;
      hold_q  <= 16'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      yield   <= yield_d;
      err     <= err_d;
      ce      <= ce_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  // Pin mux from the registered grant; pins are quiet with no owner.
  always_comb begin
    sclk   = 1'b0;
    sio_o  = 4'b0000;
    sio_oe = 4'b0000;
    if (gnt[0]) begin
      sclk   = sclk_r[0];
      sio_o  = sio_o_r0;
      sio_oe = sio_oe_r0;
    end else if (gnt[1]) begin
      sclk   = sclk_r[1];
      sio_o  = sio_o_r1;
      sio_oe = sio_oe_r1;
    end
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
module tb_qspi_bus_arbiter;

  localparam int G  = 2;
  localparam int MH = 8;

  logic       clk_osc = 1'b0;
  logic       rst_n;
  logic [1:0] req, ce_sel0, ce_sel1, done, sclk_r;
  logic [3:0] sio_o_r0, sio_o_r1, sio_oe_r0, sio_oe_r1;
  logic [1:0] gnt, yield, err;
  logic [2:0] ce;
  logic       sclk;
  logic [3:0] sio_o, sio_oe;

  qspi_bus_arbiter #(.GAP_CYCLES(G), .MAX_HOLD(MH)) dut (
    .clk_osc(clk_osc), .rst_n(rst_n), .req(req),
    .ce_sel0(ce_sel0), .ce_sel1(ce_sel1), .done(done), .sclk_r(sclk_r),
    .sio_o_r0(sio_o_r0), .sio_o_r1(sio_o_r1),
    .sio_oe_r0(sio_oe_r0), .sio_oe_r1(sio_oe_r1),
    .gnt(gnt), .yield(yield), .err(err), .ce(ce),
    .sclk(sclk), .sio_o(sio_o), .sio_oe(sio_oe)
  );

  always #5 clk_osc = ~clk_osc;

  typedef struct {
    int         cyc;
    logic [1:0] gnt;
    logic [1:0] yield;
    logic [1:0] err;
    logic [2:0] ce;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;

  // Reference model: transaction-level view of the bus.
  int         m_owner = -1;   // -1 when nobody holds the bus
  int         m_busy  = 0;    // busy cycles completed by the owner
  int         m_gap   = 0;    // CE-high cycles still to elapse
  int         m_next  = 0;    // requester favoured on contention
  logic [1:0] m_yield = 2'b00;
  logic [1:0] m_err   = 2'b00;
  logic [2:0] m_ce    = 3'b111;

  function automatic logic [1:0] owner_mask(int o);
    if (o < 0) return 2'b00;
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step(input logic [1:0] rq, input logic [1:0] dn,
                            input logic [1:0] s0, input logic [1:0] s1,
                            input logic rn);
    int         who;
    logic [1:0] sel;
    m_err = 2'b00;
    if (!rn) begin
      m_owner = -1; m_busy = 0; m_gap = 0; m_next = 0;
      m_yield = 2'b00; m_ce = 3'b111;
    end else if (m_owner >= 0) begin
      if (dn[m_owner]) begin
        m_owner = -1; m_yield = 2'b00; m_ce = 3'b111; m_gap = G;
      end else begin
        if (m_busy < 65535) m_busy++;
        m_yield = 2'b00;
        if (m_busy >= MH && rq[1 - m_owner]) m_yield = owner_mask(m_owner);
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (rq != 2'b00) begin
      if (rq == 2'b11) who = m_next;
      else             who = rq[1] ? 1 : 0;
      sel    = (who == 1) ? s1 : s0;
      m_next = 1 - who;
      if (sel == 2'd3) begin
        m_err = owner_mask(who);
      end else begin
        m_owner = who; m_busy = 0; m_yield = 2'b00;
        m_ce = 3'b111;
        m_ce[sel] = 1'b0;
      end
    end
  endtask

  // One clock of stimulus; the expected post-edge state is queued at the edge.
  task automatic cyc(input logic [1:0] rq, input logic [1:0] dn,
                     input logic [1:0] s0, input logic [1:0] s1,
                     input logic rn);
    exp_t e;
    req = rq; done = dn; ce_sel0 = s0; ce_sel1 = s1; rst_n = rn;
    sclk_r    = 2'($urandom);
    sio_o_r0  = 4'($urandom); sio_o_r1  = 4'($urandom);
    sio_oe_r0 = 4'($urandom); sio_oe_r1 = 4'($urandom);
    @(posedge clk_osc);
    cycle_no++;
    model_step(rq, dn, s0, s1, rn);
    e.cyc = cycle_no; e.gnt = owner_mask(m_owner); e.yield = m_yield;
    e.err = m_err; e.ce = m_ce;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input int c,
                     input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, c, got, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk_osc) begin
    exp_t       e;
    logic       w_sclk;
    logic [3:0] w_o, w_oe;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",   e.cyc, {2'b00, gnt},   {2'b00, e.gnt});
      chk("yield", e.cyc, {2'b00, yield}, {2'b00, e.yield});
      chk("err",   e.cyc, {2'b00, err},   {2'b00, e.err});
      chk("ce",    e.cyc, {1'b0, ce},     {1'b0, e.ce});
      w_sclk = 1'b0; w_o = 4'b0000; w_oe = 4'b0000;
      if (e.gnt == 2'b01) begin
        w_sclk = sclk_r[0]; w_o = sio_o_r0; w_oe = sio_oe_r0;
      end else if (e.gnt == 2'b10) begin
        w_sclk = sclk_r[1]; w_o = sio_o_r1; w_oe = sio_oe_r1;
      end
      chk("sclk",   e.cyc, {3'b000, sclk}, {3'b000, w_sclk});
      chk("sio_o",  e.cyc, sio_o,  w_o);
      chk("sio_oe", e.cyc, sio_oe, w_oe);
    end
  end

  initial begin
    logic [1:0] rq, dn, s0, s1;
    logic       rn;

    // Reset with both requesters asking; first grant must go to requester 0.
    repeat (2) cyc(2'b11, 2'b00, 2'd1, 2'd2, 1'b0);
    cyc(2'b11, 2'b00, 2'd1, 2'd2, 1'b1);
    repeat (3) cyc(2'b11, 2'b00, 2'd1, 2'd2, 1'b1);
    cyc(2'b11, 2'b10, 2'd1, 2'd2, 1'b1);          // non-owner done ignored
    cyc(2'b11, 2'b01, 2'd1, 2'd2, 1'b1);          // owner done
    repeat (4) cyc(2'b00, 2'b11, 2'd0, 2'd0, 1'b1); // done in GAP/IDLE ignored

    // Single transfer on chip 1, then early re-request during the gap.
    cyc(2'b01, 2'b00, 2'd1, 2'd0, 1'b1);
    repeat (3) cyc(2'b00, 2'b00, 2'd2, 2'd0, 1'b1); // req drop, sel change ignored
    cyc(2'b00, 2'b01, 2'd1, 2'd0, 1'b1);
    repeat (5) cyc(2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    cyc(2'b01, 2'b01, 2'd0, 2'd0, 1'b1);
    repeat (3) cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b1);

    // Round-robin with continuous contention.
    for (int t = 0; t < 4; t++) begin
      repeat (3) cyc(2'b11, 2'b00, 2'd0, 2'd2, 1'b1);
      cyc(2'b11, 2'b11, 2'd0, 2'd2, 1'b1);
    end
    repeat (4) cyc(2'b00, 2'b11, 2'd0, 2'd0, 1'b1);

    // Yield: requester 0 holds past MAX_HOLD with requester 1 waiting.
    cyc(2'b01, 2'b00, 2'd2, 2'd1, 1'b1);
    repeat (12) cyc(2'b11, 2'b00, 2'd2, 2'd1, 1'b1);
    repeat (2) cyc(2'b01, 2'b00, 2'd2, 2'd1, 1'b1); // non-owner drops: yield clears
    repeat (2) cyc(2'b11, 2'b00, 2'd2, 2'd1, 1'b1);
    cyc(2'b11, 2'b01, 2'd2, 2'd1, 1'b1);
    repeat (5) cyc(2'b10, 2'b00, 2'd2, 2'd1, 1'b1);
    cyc(2'b10, 2'b10, 2'd2, 2'd1, 1'b1);
    repeat (3) cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b1);

    // Illegal select, then a legal request from the other side.
    cyc(2'b10, 2'b00, 2'd0, 2'd3, 1'b1);
    cyc(2'b01, 2'b00, 2'd0, 2'd3, 1'b1);
    repeat (2) cyc(2'b00, 2'b00, 2'd0, 2'd3, 1'b1);
    cyc(2'b00, 2'b01, 2'd0, 2'd3, 1'b1);
    repeat (3) cyc(2'b00, 2'b00, 2'd0, 2'd0, 1'b1);

    // Reset in the middle of a transaction, then a fresh grant.
    cyc(2'b10, 2'b00, 2'd0, 2'd2, 1'b1);
    repeat (4) cyc(2'b11, 2'b00, 2'd0, 2'd2, 1'b1);
    cyc(2'b11, 2'b00, 2'd0, 2'd2, 1'b0);
    cyc(2'b10, 2'b00, 2'd0, 2'd2, 1'b1);
    repeat (3) cyc(2'b10, 2'b00, 2'd0, 2'd2, 1'b1);
    cyc(2'b10, 2'b10, 2'd0, 2'd2, 1'b1);

    // Randomised traffic.
    rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 2'($urandom);
      dn = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      s0 = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      s1 = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rn = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      cyc(rq, dn, s0, s1, rn);
    end

    @(negedge clk_osc);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_bus_arbiter.md
# qspi_bus_arbiter

Arbitrates the SoC's shared quad-SPI pin group (sclk, sio[3:0], ce[2:0]) between two requesters inside `soc`: requester 0 is instruction fetch and requester 1 is the data load/store port. The block grants the bus round-robin and drives the selected chip-enable. It enforces a minimum CE-high gap between transactions and asks a long-running owner to yield when the other side is waiting. It also muxes the owner's sclk and sio outputs onto the pins.

## Interface
- `GAP_CYCLES`, default 2: minimum idle cycles with all CE high after a transaction (0..15).
- `MAX_HOLD`, default 64: number of busy cycles after which `yield` is raised if the other requester is waiting (1..65535).
- `clk_osc`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  2  per-requester bus request (level).
- `ce_sel0`, `ce_sel1`  in  2 each  target chip for each requester; values 0..2 are valid, 3 is illegal.
- `done`  in  2  per-requester end-of-transaction pulse; honoured only while that requester holds `gnt`.
- `sclk_r`  in  2  per-requester SPI clock.
- `sio_o_r0`, `sio_o_r1`  in  4 each  per-requester sio output data.
- `sio_oe_r0`, `sio_oe_r1`  in  4 each  per-requester sio output enables.
- `gnt`  out  2  registered grant, one-hot or zero.
- `yield`  out  2  registered request to the owner to finish its transaction.
- `err`  out  2  one-cycle pulse when a request is rejected because its `ce_sel` is 3.
- `ce`  out  3  active-low chip enables to pins.
- `sclk`  out  1  muxed SPI clock.
- `sio_o`  out  4  muxed sio output data.
- `sio_oe`  out  4  muxed sio output enables.

## Operation
- State machine states: IDLE, BUSY, GAP.
- Reset values: state IDLE, `gnt`=00, `yield`=00, `err`=00, `ce`=111, and the round-robin pointer favours requester 0.
- **IDLE, grant selection**
  - If exactly one `req` bit is set, that requester is chosen.
  - If both are set, the requester named by the pointer is chosen.
- **IDLE, chosen requester has a valid `ce_sel`**
  - Next cycle: `gnt[i]`=1 and `ce[ce_sel_i]`=0.
  - The pointer moves to the other requester.
  - The hold counter clears and the state becomes BUSY.
- **IDLE, chosen requester has `ce_sel`=3**
  - Next cycle: `err[i]`=1 for one cycle and the pointer moves to the other requester.
  - The state stays IDLE and `ce` is not touched.
- **BUSY**
  - The hold counter (16 bits) increments every cycle and saturates.
  - `ce_sel` is latched at grant, so later changes are ignored until the next grant.
  - `req` deasserting without `done` has no effect; the transaction continues.
  - `yield[owner]` is set when hold count ≥ `MAX_HOLD` and the non-owner `req`=1. It is cleared when the non-owner drops `req` or when the transaction ends.
  - On `done[owner]`: next cycle `gnt`=00, `yield`=00 and `ce`=111.
  - After `done[owner]`, the state moves to GAP with the gap counter loaded to `GAP_CYCLES`−1, or to IDLE if `GAP_CYCLES`=0.
- **GAP**
  - Requests are not evaluated.
  - The gap counter counts down; the state moves to IDLE after the cycle in which it reads 0.
- **`done` filtering:** `done` from the non-owner, and any `done` in IDLE or GAP, is ignored.
- **Pin mux** (combinational from registered `gnt`):
  - The owner's `sclk_r`, `sio_o_r*` and `sio_oe_r*` drive the pins.
  - With no owner: `sclk`=0, `sio_o`=0000, `sio_oe`=0000.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N gives `gnt` and CE low from cycle N+1.
- Release: `done` sampled at edge M gives `gnt`=00 and `ce`=111 from cycle M+1.
- With `GAP_CYCLES`=G>0, the state is GAP for cycles M+1..M+G and IDLE at M+G+1. The earliest next grant is visible at M+G+2.
- CE-high between transactions is therefore at least G+1 cycles. With G=0 it is exactly 1 cycle.
- `yield` is registered: it rises one cycle after the condition first holds.
- `err` pulse latency is 1 cycle from the sampled request.
- Reset mid-operation: `rst_n` sampled low at any edge gives reset values in the next cycle, regardless of state. No `done` is required afterwards.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with both `req` high → `ce`=111, `gnt`=00, `sclk`=0, `sio_oe`=0000 throughout; the first grant after release goes to requester 0.
- Single transfer: `req`=01 with `ce_sel0`=1 → next cycle `gnt`=01 and `ce`=101, and the pins follow requester 0; `done`=01 at cycle M → `ce`=111 at M+1 and no grant before M+4 (G=2).
- Round-robin: both `req` held high continuously with valid selects, each transaction ending with `done` → grants alternate 01, 10, 01, 10; consecutive CE-low windows are separated by ≥3 cycles.
- Yield: `MAX_HOLD`=8, requester 0 granted, `req`=11 throughout → `yield`=01 from busy cycle 9 until `done`; then requester 1 is granted after the gap.
- Illegal select: `ce_sel1`=3 with `req`=10 → `err`=10 for one cycle, `ce` stays 111; a subsequent `req`=01 is granted on the next evaluation.
- Reset mid-BUSY: drive `rst_n` low at busy cycle 5 → next cycle `gnt`=00, `ce`=111, `yield`=00; then a fresh `req` is granted normally.
